// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// Optional two-stop-bit framing is selected in uart_tx_core via UART_TX_TWO_STOP_EN.
package uart_pkg;

    localparam int DATA_W = 8;
    localparam int BIT_W  = $clog2(DATA_W);

    // 2'b11 is treated exactly like PAR_NONE; it is named so casts stay in range.
    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_ODD  = 2'b01,
        PAR_EVEN = 2'b10,
        PAR_RSVD = 2'b11
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } tx_state_e;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic logic parity_enabled(input parity_e p);
        return (p == PAR_ODD) || (p == PAR_EVEN);
    endfunction

    // Even selection sends the plain XOR of the data bits, odd sends its inverse.
    function automatic logic parity_bit(input logic [DATA_W-1:0] d, input parity_e p);
        return (p == PAR_ODD) ? ~(^d) : (^d);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..DIV-1 for the selected divisor and pulses
// bit_tick on the last cycle of each bit. Held at zero while restart is high.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV0 = 5208,
    parameter int DIV1 = 2604,
    parameter int DIV2 = 868,
    parameter int DIV3 = 434
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic [1:0] baud_sel,
    input  logic       restart,
    output logic       bit_tick
);

    localparam int MAX_DIV = max4(DIV0, DIV1, DIV2, DIV3);
    localparam int CNT_W   = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] div_m1;

    always_comb begin
        div_m1 = '0;
        unique case (baud_sel)
            2'b00: div_m1 = CNT_W'(DIV0 - 1);
            2'b01: div_m1 = CNT_W'(DIV1 - 1);
            2'b10: div_m1 = CNT_W'(DIV2 - 1);
            2'b11: div_m1 = CNT_W'(DIV3 - 1);
        endcase
    end

    assign bit_tick = !restart && (baud_cnt == div_m1);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            baud_cnt <= '0;
        end else if (restart || (baud_cnt == div_m1)) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, stop.
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
//
// state  | meaning
// IDLE   | line high, waiting for send with tx_enable
// START  | start bit (low) for one bit period
// DATA   | shadow data bit bit_idx, LSB first
// PARITY | parity bit, only when shadow parity is odd or even
// STOP   | stop bit(s), line high
// DONE   | tx_done_flag high until the bridge drops send
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DIV0 = 5208,
    parameter int DIV1 = 2604,
    parameter int DIV2 = 868,
    parameter int DIV3 = 434
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       tx_enable,
    input  logic       send,
    input  logic [7:0] DATA_TX,
    input  logic [1:0] parity_type,
    input  logic [1:0] baud_rate,
    output logic       tx,
    output logic       tx_active_flag,
    output logic       tx_done_flag
);

    tx_state_e          state;
    tx_state_e          state_nxt;
    logic               load;
    logic               bit_tick;
    logic               last_stop;
    logic [BIT_W-1:0]   bit_idx;
    logic [DATA_W-1:0]  sh_data;
    parity_e            sh_par;
    logic [1:0]         sh_baud;

    uart_baud_gen #(
        .DIV0 (DIV0),
        .DIV1 (DIV1),
        .DIV2 (DIV2),
        .DIV3 (DIV3)
    ) u_baud_gen (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .baud_sel (sh_baud),
        .restart  (!tx_active_flag),
        .bit_tick (bit_tick)
    );

`ifdef UART_TX_TWO_STOP_EN
    logic stop_second;

    assign last_stop = stop_second;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            stop_second <= 1'b0;
        end else if (load) begin
            stop_second <= 1'b0;
        end else if ((state == ST_STOP) && bit_tick) begin
            stop_second <= ~stop_second;
        end
    end
`else
    assign last_stop = 1'b1;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= ST_IDLE;
            bit_idx <= '0;
            sh_data <= '0;
            sh_par  <= PAR_NONE;
            sh_baud <= 2'b00;
        end else begin
            state <= state_nxt;
            if (load) begin
                sh_data <= DATA_TX;
                sh_par  <= parity_e'(parity_type);
                sh_baud <= baud_rate;
                bit_idx <= '0;
            end else if ((state == ST_DATA) && bit_tick) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        load           = 1'b0;
        tx             = 1'b1;
        tx_active_flag = 1'b0;
        tx_done_flag   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (send && tx_enable) begin
                    load      = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                tx             = 1'b0;
                tx_active_flag = 1'b1;
                if (bit_tick) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                tx             = sh_data[bit_idx];
                tx_active_flag = 1'b1;
                if (bit_tick && (bit_idx == BIT_W'(DATA_W - 1))) begin
                    state_nxt = parity_enabled(sh_par) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                tx             = parity_bit(sh_data, sh_par);
                tx_active_flag = 1'b1;
                if (bit_tick) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                tx_active_flag = 1'b1;
                if (bit_tick && last_stop) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                tx_done_flag = 1'b1;
                // Waiting for send low keeps a held request from starting another frame.
                if (!send) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core with small divisors (16/8/4/2).
module tb_uart_tx_core;

    logic       PCLK;
    logic       PRESETn;
    logic       tx_enable;
    logic       send;
    logic [7:0] DATA_TX;
    logic [1:0] parity_type;
    logic [1:0] baud_rate;
    logic       tx;
    logic       tx_active_flag;
    logic       tx_done_flag;

    int checks = 0;
    int errors = 0;

`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

    uart_tx_core #(
        .DIV0 (16),
        .DIV1 (8),
        .DIV2 (4),
        .DIV3 (2)
    ) dut (
        .PCLK           (PCLK),
        .PRESETn        (PRESETn),
        .tx_enable      (tx_enable),
        .send           (send),
        .DATA_TX        (DATA_TX),
        .parity_type    (parity_type),
        .baud_rate      (baud_rate),
        .tx             (tx),
        .tx_active_flag (tx_active_flag),
        .tx_done_flag   (tx_done_flag)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // bits: start + data (+ parity), first-sent bit at index 0; stop bits appended here.
    task automatic run_frame(input string name, input logic [7:0] data, input logic [1:0] par,
                             input logic [1:0] baud, input int div, input logic [11:0] bits,
                             input int nbits, input int disturb_at);
        int   total;
        logic exp_tx;
        bit   reported;
        reported    = 0;
        DATA_TX     = data;
        parity_type = par;
        baud_rate   = baud;
        tx_enable   = 1'b1;
        send        = 1'b1;
        step();
        total = (nbits + STOP_BITS) * div;
        for (int c = 0; c < total; c++) begin
            exp_tx = ((c / div) < nbits) ? bits[c / div] : 1'b1;
            checks++;
            if ((tx !== exp_tx) || (tx_active_flag !== 1'b1) || (tx_done_flag !== 1'b0)) begin
                errors++;
                if (!reported)
                    $display("FAIL %s cycle %0d: tx=%b active=%b done=%b, required tx=%b active=1 done=0",
                             name, c, tx, tx_active_flag, tx_done_flag, exp_tx);
                reported = 1;
            end
            if (c == disturb_at) begin
                baud_rate = 2'b00;
                DATA_TX   = 8'hFF;
                tx_enable = 1'b0;
            end
            step();
        end
        checks++;
        if ((tx !== 1'b1) || (tx_active_flag !== 1'b0) || (tx_done_flag !== 1'b1)) begin
            errors++;
            $display("FAIL %s end: tx=%b active=%b done=%b, required tx=1 active=0 done=1",
                     name, tx, tx_active_flag, tx_done_flag);
        end
    endtask

    task automatic release_send(input string name);
        send = 1'b0;
        step();
        checks++;
        if ((tx !== 1'b1) || (tx_active_flag !== 1'b0) || (tx_done_flag !== 1'b0)) begin
            errors++;
            $display("FAIL %s idle: tx=%b active=%b done=%b, required tx=1 active=0 done=0",
                     name, tx, tx_active_flag, tx_done_flag);
        end
    endtask

    task automatic test_reset();
        PRESETn     = 1'b0;
        tx_enable   = 1'b0;
        send        = 1'b0;
        DATA_TX     = 8'h00;
        parity_type = 2'b00;
        baud_rate   = 2'b00;
        repeat (3) step();
        checks++;
        if ((tx !== 1'b1) || (tx_active_flag !== 1'b0) || (tx_done_flag !== 1'b0)) begin
            errors++;
            $display("FAIL reset_hold: tx=%b active=%b done=%b, required 1 0 0",
                     tx, tx_active_flag, tx_done_flag);
        end
        PRESETn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            checks++;
            if ((tx !== 1'b1) || (tx_active_flag !== 1'b0) || (tx_done_flag !== 1'b0)) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: tx=%b active=%b done=%b, required 1 0 0",
                         i, tx, tx_active_flag, tx_done_flag);
            end
        end
    endtask

    task automatic test_basic_frame();
        // 8'hA5 LSB first: 1,0,1,0,0,1,0,1
        run_frame("a5_none", 8'hA5, 2'b00, 2'b00, 16, {8'hA5, 1'b0}, 9, -1);
    endtask

    task automatic test_held_send();
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if ((tx !== 1'b1) || (tx_active_flag !== 1'b0) || (tx_done_flag !== 1'b1)) begin
                errors++;
                $display("FAIL held_send cycle %0d: tx=%b active=%b done=%b, required 1 0 1",
                         i, tx, tx_active_flag, tx_done_flag);
            end
        end
        release_send("held_send");
    endtask

    task automatic test_parity();
        // 8'h07 has three ones: even-select sends 1, odd-select sends 0
        run_frame("07_even", 8'h07, 2'b10, 2'b11, 2, {1'b1, 8'h07, 1'b0}, 10, -1);
        release_send("07_even");
        run_frame("07_odd", 8'h07, 2'b01, 2'b11, 2, {1'b0, 8'h07, 1'b0}, 10, -1);
        release_send("07_odd");
        run_frame("07_rsvd", 8'h07, 2'b11, 2'b11, 2, {8'h07, 1'b0}, 9, -1);
        release_send("07_rsvd");
    endtask

    task automatic test_mid_frame_disturb();
        run_frame("3c_disturb", 8'h3C, 2'b00, 2'b01, 8, {8'h3C, 1'b0}, 9, 20);
        release_send("3c_disturb");
    endtask

    task automatic test_enable_blocked();
        tx_enable = 1'b0;
        send      = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            checks++;
            if ((tx !== 1'b1) || (tx_active_flag !== 1'b0) || (tx_done_flag !== 1'b0)) begin
                errors++;
                $display("FAIL enable_blocked cycle %0d: tx=%b active=%b done=%b, required 1 0 0",
                         i, tx, tx_active_flag, tx_done_flag);
            end
        end
        send = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        // 8'h52: bit 3 is 0, so the reset produces a visible rise on tx
        DATA_TX     = 8'h52;
        parity_type = 2'b00;
        baud_rate   = 2'b10;
        tx_enable   = 1'b1;
        send        = 1'b1;
        step();
        repeat (18) step();
        checks++;
        if ((tx !== 1'b0) || (tx_active_flag !== 1'b1)) begin
            errors++;
            $display("FAIL pre_reset_bit3: tx=%b active=%b, required tx=0 active=1", tx, tx_active_flag);
        end
        #2 PRESETn = 1'b0;
        #1;
        checks++;
        if ((tx !== 1'b1) || (tx_active_flag !== 1'b0) || (tx_done_flag !== 1'b0)) begin
            errors++;
            $display("FAIL async_reset: tx=%b active=%b done=%b, required 1 0 0",
                     tx, tx_active_flag, tx_done_flag);
        end
        send = 1'b0;
        step();
        PRESETn = 1'b1;
        step();
        checks++;
        if ((tx !== 1'b1) || (tx_active_flag !== 1'b0) || (tx_done_flag !== 1'b0)) begin
            errors++;
            $display("FAIL post_reset_idle: tx=%b active=%b done=%b, required 1 0 0",
                     tx, tx_active_flag, tx_done_flag);
        end
        // 8'hC3 has four ones: even-select sends 0
        run_frame("c3_after_reset", 8'hC3, 2'b10, 2'b10, 4, {1'b0, 8'hC3, 1'b0}, 10, -1);
        release_send("c3_after_reset");
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_held_send();
        test_parity();
        test_mid_frame_disturb();
        test_enable_blocked();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
